// File: rtl/time_of_day_counter.sv
// Time-of-day counter: BCD hh:mm:ss driven by a 1 Hz strobe, with a set mode,
// 24 h or 12 h AM/PM counting and a one-cycle day-rollover pulse.
module time_of_day_counter #(
   parameter bit MODE_24H = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       set_en,
   input  logic       inc_min,
   input  logic       inc_hour,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] hr_tens,
   output logic       pm,
   output logic       day_tick
);

   typedef enum logic {RUN = 1'b0, SET = 1'b1} mode_t;

   // Next value of a 00..59 BCD field plus its carry out.
   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       carry;
   } d60_t;

   // Next hour digits, pm flag and whether this step is the midnight rollover.
   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       pm;
      logic       day;
   } hour_t;

   localparam logic [3:0] HR_RST_T = MODE_24H ? 4'd0 : 4'd1;
   localparam logic [3:0] HR_RST_O = MODE_24H ? 4'd0 : 4'd2;

   function automatic d60_t step60(input logic [3:0] t, input logic [3:0] o);
      d60_t r;
      r.tens  = t;
      r.ones  = o + 4'd1;
      r.carry = 1'b0;
      if (o == 4'd9) begin
         r.ones = 4'd0;
         if (t == 4'd5) begin
            r.tens  = 4'd0;
            r.carry = 1'b1;
         end else begin
            r.tens = t + 4'd1;
         end
      end
      return r;
   endfunction

   function automatic hour_t hour_step(input logic [3:0] t, input logic [3:0] o,
                                       input logic p);
      hour_t h;
      h.tens = t;
      h.ones = o + 4'd1;
      h.pm   = p;
      h.day  = 1'b0;
      if (MODE_24H) begin
         if (t == 4'd2 && o == 4'd3) begin
            h.tens = 4'd0;
            h.ones = 4'd0;
            h.day  = 1'b1;
         end else if (o == 4'd9) begin
            h.tens = t + 4'd1;
            h.ones = 4'd0;
         end
      end else begin
         if (t == 4'd1 && o == 4'd2) begin
            // 12 -> 01 keeps the half-day
            h.tens = 4'd0;
            h.ones = 4'd1;
         end else if (t == 4'd1 && o == 4'd1) begin
            // 11 -> 12 flips AM/PM; leaving PM is midnight
            h.ones = 4'd2;
            h.pm   = ~p;
            h.day  = p;
         end else if (o == 4'd9) begin
            h.tens = 4'd1;
            h.ones = 4'd0;
         end
      end
      return h;
   endfunction

   mode_t      state;
   logic [3:0] sec_base_t, sec_base_o;
   d60_t       sec_nx, min_nx;
   hour_t      hr_nx;
   logic [3:0] n_so, n_st, n_mo, n_mt, n_ho, n_ht;
   logic       n_pm, n_day;

   // First run cycle after set mode counts from a clean 00 seconds.
   assign sec_base_t = (state == SET) ? 4'd0 : sec_tens;
   assign sec_base_o = (state == SET) ? 4'd0 : sec_ones;
   assign sec_nx     = step60(sec_base_t, sec_base_o);
   assign min_nx     = step60(min_tens, min_ones);
   assign hr_nx      = hour_step(hr_tens, hr_ones, pm);

   // Next-state selection; set_en takes priority so a coincident tick is dropped.
   always_comb begin
      n_so  = sec_ones;
      n_st  = sec_tens;
      n_mo  = min_ones;
      n_mt  = min_tens;
      n_ho  = hr_ones;
      n_ht  = hr_tens;
      n_pm  = pm;
      n_day = 1'b0;
      if (set_en) begin
         n_so = 4'd0;
         n_st = 4'd0;
         if (inc_min) begin
            n_mt = min_nx.tens;
            n_mo = min_nx.ones;
         end
         if (inc_hour) begin
            n_ht = hr_nx.tens;
            n_ho = hr_nx.ones;
            n_pm = hr_nx.pm;
         end
      end else if (tick) begin
         n_st = sec_nx.tens;
         n_so = sec_nx.ones;
         if (sec_nx.carry) begin
            n_mt = min_nx.tens;
            n_mo = min_nx.ones;
            if (min_nx.carry) begin
               n_ht  = hr_nx.tens;
               n_ho  = hr_nx.ones;
               n_pm  = hr_nx.pm;
               n_day = hr_nx.day;
            end
         end
      end
   end

   // Mode FSM tracks set_en every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RUN;
      else        state <= set_en ? SET : RUN;
   end

   // Registered time digits and rollover pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sec_ones <= 4'd0;
         sec_tens <= 4'd0;
         min_ones <= 4'd0;
         min_tens <= 4'd0;
         hr_ones  <= HR_RST_O;
         hr_tens  <= HR_RST_T;
         pm       <= 1'b0;
         day_tick <= 1'b0;
      end else begin
         sec_ones <= n_so;
         sec_tens <= n_st;
         min_ones <= n_mo;
         min_tens <= n_mt;
         hr_ones  <= n_ho;
         hr_tens  <= n_ht;
         pm       <= n_pm;
         day_tick <= n_day;
      end
   end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: a 24 h and a 12 h instance, each tracked by a
// seconds-of-day reference model through an expected-value queue.
module tb_time_of_day_counter;

   typedef struct packed {
      logic [3:0] ht, ho, mt, mo, st, so;
      logic       pm, day;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] tick = '0, set_en = '0, inc_min = '0, inc_hour = '0;
   logic [3:0] so [2], st [2], mo [2], mt [2], ho [2], ht [2];
   logic [1:0] pm, day_tick;

   int   total = 0, bad = 0;
   int   tod  [2];   // seconds since midnight
   bit   dayf [2];
   exp_t q0[$], q1[$];

   always #5 clk = ~clk;

   time_of_day_counter #(.MODE_24H(1'b1)) dut24 (
      .clk(clk), .reset(reset), .tick(tick[0]), .set_en(set_en[0]),
      .inc_min(inc_min[0]), .inc_hour(inc_hour[0]),
      .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
      .hr_ones(ho[0]), .hr_tens(ht[0]), .pm(pm[0]), .day_tick(day_tick[0]));

   time_of_day_counter #(.MODE_24H(1'b0)) dut12 (
      .clk(clk), .reset(reset), .tick(tick[1]), .set_en(set_en[1]),
      .inc_min(inc_min[1]), .inc_hour(inc_hour[1]),
      .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
      .hr_ones(ho[1]), .hr_tens(ht[1]), .pm(pm[1]), .day_tick(day_tick[1]));

   // Display the model time in the format the instance should show.
   function automatic exp_t model_out(input int d);
      exp_t e;
      int   h24, h, m, s;
      h24 = tod[d] / 3600;
      m   = (tod[d] / 60) % 60;
      s   = tod[d] % 60;
      h   = h24;
      e.pm = 1'b0;
      if (d == 1) begin
         e.pm = (h24 >= 12);
         h    = (h24 % 12 == 0) ? 12 : h24 % 12;
      end
      e.ht  = 4'(h / 10);
      e.ho  = 4'(h % 10);
      e.mt  = 4'(m / 10);
      e.mo  = 4'(m % 10);
      e.st  = 4'(s / 10);
      e.so  = 4'(s % 10);
      e.day = dayf[d];
      return e;
   endfunction

   function automatic exp_t actual(input int d);
      return {ht[d], ho[d], mt[d], mo[d], st[d], so[d], pm[d], day_tick[d]};
   endfunction

   // Advance the reference model by one clock with the given inputs.
   task automatic model_step(input int d, input bit rst, input bit tk, input bit se,
                             input bit im, input bit ih);
      int h, m, nh, nm;
      dayf[d] = 1'b0;
      if (rst) begin
         tod[d] = 0;
      end else if (se) begin
         h  = tod[d] / 3600;
         m  = (tod[d] / 60) % 60;
         nh = ih ? (h + 1) % 24 : h;
         nm = im ? (m + 1) % 60 : m;
         tod[d] = nh * 3600 + nm * 60;
      end else if (tk) begin
         tod[d]  = (tod[d] + 1) % 86400;
         dayf[d] = (tod[d] == 0);
      end
   endtask

   // One clock of stimulus. d selects the instance (2 = both); the other idles.
   task automatic cyc(input int d, input bit tk, input bit se, input bit im,
                      input bit ih, input bit rst = 1'b0);
      @(negedge clk);
      reset = ~rst;
      for (int i = 0; i < 2; i++) begin
         bit on;
         on = (d == 2) || (d == i);
         tick[i]     = on & tk;
         set_en[i]   = on & se;
         inc_min[i]  = on & im;
         inc_hour[i] = on & ih;
         model_step(i, rst, on & tk, on & se, on & im, on & ih);
      end
      q0.push_back(model_out(0));
      q1.push_back(model_out(1));
   endtask

   // Bring instance d to hh:mm:ss (24 h clock) through set mode and ticks.
   task automatic goto_time(input int d, input int hh, input int mm, input int ss);
      cyc(d, 0, 1, 0, 0);
      while (tod[d] / 3600 != hh)         cyc(d, 0, 1, 0, 1);
      while ((tod[d] / 60) % 60 != mm)    cyc(d, 0, 1, 1, 0);
      cyc(d, 0, 0, 0, 0);
      for (int i = 0; i < ss; i++) begin
         cyc(d, 1, 0, 0, 0);
         cyc(d, 0, 0, 0, 0);
      end
   endtask

   // Scoreboard monitor: every output cycle is checked against the queue head.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         total++;
         if (actual(0) !== e) begin
            bad++;
            $display("FAIL dut24 time: got %h want %h (hh mm ss pm day)", actual(0), e);
         end
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         total++;
         if (actual(1) !== e) begin
            bad++;
            $display("FAIL dut12 time: got %h want %h (hh mm ss pm day)", actual(1), e);
         end
      end
   end

   initial begin
      bit last_tk;
      tod[0] = 0; tod[1] = 0; dayf[0] = 0; dayf[1] = 0;
      // reset state
      cyc(2, 0, 0, 0, 0, 1);
      cyc(2, 1, 0, 0, 0, 1);
      // 60 ticks on both instances
      for (int i = 0; i < 60; i++) begin
         cyc(2, 1, 0, 0, 0);
         cyc(2, 0, 0, 0, 0);
      end
      // 24 h midnight rollover
      goto_time(0, 23, 59, 59);
      cyc(0, 1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      // 12 h noon, 12 -> 01 and midnight
      goto_time(1, 11, 59, 59);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      goto_time(1, 12, 59, 59);
      cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      goto_time(1, 23, 59, 59);
      cyc(1, 1, 0, 0, 0);
      repeat (2) cyc(1, 0, 0, 0, 0);
      // set mode: seconds cleared, no minute carry, ticks ignored, dual increment
      goto_time(0, 10, 59, 37);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 1, 1, 1);
      cyc(0, 0, 0, 0, 0);
      // reset mid-count, with tick high while reset is held
      goto_time(0, 5, 17, 42);
      cyc(2, 1, 0, 0, 0, 1);
      cyc(2, 0, 0, 0, 0, 1);
      cyc(2, 0, 0, 0, 0);
      // tick coincident with entering set mode
      goto_time(0, 0, 0, 8);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      // random traffic on both instances
      last_tk = 0;
      for (int i = 0; i < 3000; i++) begin
         bit tk, se, rst;
         tk  = !last_tk && ($urandom_range(0, 2) == 0);
         se  = ($urandom_range(0, 9) < 3);
         rst = ($urandom_range(0, 499) == 0);
         last_tk = tk;
         cyc(2, tk, se, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, rst);
      end
      repeat (3) @(negedge clk);
      total++;
      if (q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d/%0d queued want 0/0", q0.size(), q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
